// File: rtl/tiny_pkg.sv
// Defaults shared by the register-file write-back controller and its helpers.
// NUM_REGS tracks the default address width; the controller derives its own count from ADDR_W.
package tiny_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// When both ports request, the port that was granted less recently wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Set when port 1 should win the next contention; cleared by reset so port 0 starts ahead.
    logic prefer_p1;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prefer_p1 ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_p1 <= 1'b0;
        end else if (grant != 2'b00) begin
            prefer_p1 <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: destination scoreboard, two-port write-back arbitration,
// registered register-file write port and decode hazard detection.
module regfile_wb_ctrl
    import tiny_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic                 rsv_ready,
    input  logic                 req0_valid,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic [DATA_W-1:0]    req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_W-1:0]    req1_addr,
    input  logic [DATA_W-1:0]    req1_data,
    output logic                 req1_ready,
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic                 hazard,
    output logic                 write,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] set_mask;
    logic [N_REGS-1:0] clr_mask;
    logic [1:0]        req_v;
    logic [1:0]        grant;
    logic              granted;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic              hz1;
    logic              hz2;

    // Requests are masked during reset so nothing is granted and the pointer holds.
    assign req_v = {req1_valid, req0_valid} & {2{~rst}};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_v),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign granted    = |grant;
    assign g_addr     = grant[1] ? req1_addr : req0_addr;
    assign g_data     = grant[1] ? req1_data : req0_data;

    assign rsv_ready  = ~rst && ((rsv_addr == '0) || ~busy_q[rsv_addr]);
    assign busy       = busy_q;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && rsv_ready && (rsv_addr != '0)) begin
            set_mask[rsv_addr] = 1'b1;
        end
        if (granted) begin
            clr_mask[g_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            write   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            // Bit 0 is forced low so r0 never appears busy.
            busy_q  <= ((busy_q & ~clr_mask) | set_mask) & ~N_REGS'(1);
            write   <= granted && (g_addr != '0);
            if (granted) begin
                wr_addr <= g_addr;
                wr_data <= g_data;
            end
        end
    end

    // The in-flight write counts as busy until the register file has taken it.
    assign hz1    = (rd_addr1 != '0) && (busy_q[rd_addr1] || (write && (wr_addr == rd_addr1)));
    assign hz2    = (rd_addr2 != '0) && (busy_q[rd_addr2] || (write && (wr_addr == rd_addr2)));
    assign hazard = hz1 || hz2;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rsv_valid;
    logic [2:0] rsv_addr;
    logic       rsv_ready;
    logic       req0_valid;
    logic [2:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic       hazard;
    logic       write;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .hazard     (hazard),
        .write      (write),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsv_valid  = 1'b0;
        rsv_addr   = '0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;
        rd_addr1   = '0;
        rd_addr2   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rsv_valid  = 1'b1;
        rsv_addr   = 3'd0;
        req0_valid = 1'b1;
        req0_addr  = 3'd2;
        #1;
        tests_run++;
        if (busy !== 8'h00) begin tests_failed++; $display("FAIL reset_busy got %h exp 00", busy); end
        tests_run++;
        if (write !== 1'b0) begin tests_failed++; $display("FAIL reset_write got %b exp 0", write); end
        tests_run++;
        if (wr_addr !== 3'd0 || wr_data !== 8'h00) begin
            tests_failed++; $display("FAIL reset_wr got %0d/%h exp 0/00", wr_addr, wr_data);
        end
        tests_run++;
        if (rsv_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rsv_ready got %b exp 0", rsv_ready); end
        tests_run++;
        if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_writeback();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd3;
        #1;
        tests_run++;
        if (rsv_ready !== 1'b1) begin tests_failed++; $display("FAIL single_rsv_ready got %b exp 1", rsv_ready); end
        tick();
        rsv_valid = 1'b0;
        tests_run++;
        if (busy !== 8'h08) begin tests_failed++; $display("FAIL single_busy_set got %h exp 08", busy); end
        req0_valid = 1'b1;
        req0_addr  = 3'd3;
        req0_data  = 8'h5A;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++; $display("FAIL single_grant got %b%b exp 01", req1_ready, req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        tests_run++;
        if (busy !== 8'h00) begin tests_failed++; $display("FAIL single_busy_clr got %h exp 00", busy); end
        tests_run++;
        if (write !== 1'b1 || wr_addr !== 3'd3 || wr_data !== 8'h5A) begin
            tests_failed++; $display("FAIL single_wr got %b/%0d/%h exp 1/3/5a", write, wr_addr, wr_data);
        end
        tick();
        tests_run++;
        if (write !== 1'b0) begin tests_failed++; $display("FAIL single_wr_drop got %b exp 0", write); end
    endtask

    task automatic test_hazard();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd5;
        tick();
        rsv_valid = 1'b0;
        rd_addr1  = 3'd5;
        rd_addr2  = 3'd0;
        #1;
        tests_run++;
        if (hazard !== 1'b1) begin tests_failed++; $display("FAIL hazard_busy got %b exp 1", hazard); end
        req1_valid = 1'b1;
        req1_addr  = 3'd5;
        req1_data  = 8'h33;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || hazard !== 1'b1) begin
            tests_failed++; $display("FAIL hazard_pre_grant got rdy %b hz %b exp 1 1", req1_ready, hazard);
        end
        tick();
        req1_valid = 1'b0;
        tests_run++;
        if (hazard !== 1'b1 || busy !== 8'h00) begin
            tests_failed++; $display("FAIL hazard_inflight got hz %b busy %h exp 1 00", hazard, busy);
        end
        tick();
        tests_run++;
        if (hazard !== 1'b0) begin tests_failed++; $display("FAIL hazard_release got %b exp 0", hazard); end
        rd_addr1 = 3'd0;
        rd_addr2 = 3'd0;
    endtask

    task automatic test_round_robin();
        // Port 1 was granted last, so port 0 leads the contention.
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h22;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL rr_grant0 got %b%b exp 01", req1_ready, req0_ready);
        end
        tick();
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b10 || write !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL rr_cycle1 got gnt %b%b wr %b/%0d/%h exp 10 1/1/11", req1_ready, req0_ready, write, wr_addr, wr_data);
        end
        tick();
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01 || write !== 1'b1 || wr_addr !== 3'd2 || wr_data !== 8'h22) begin
            tests_failed++;
            $display("FAIL rr_cycle2 got gnt %b%b wr %b/%0d/%h exp 01 1/2/22", req1_ready, req0_ready, write, wr_addr, wr_data);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests_run++;
        if (write !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 8'h11) begin
            tests_failed++; $display("FAIL rr_cycle3 got %b/%0d/%h exp 1/1/11", write, wr_addr, wr_data);
        end
        tick();
    endtask

    task automatic test_reservation_rules();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd4;
        tick();
        #1;
        tests_run++;
        if (rsv_ready !== 1'b0) begin tests_failed++; $display("FAIL rsv_busy_ready got %b exp 0", rsv_ready); end
        tick();
        tests_run++;
        if (busy !== 8'h10) begin tests_failed++; $display("FAIL rsv_busy_hold got %h exp 10", busy); end
        rsv_addr = 3'd0;
        #1;
        tests_run++;
        if (rsv_ready !== 1'b1) begin tests_failed++; $display("FAIL rsv_r0_ready got %b exp 1", rsv_ready); end
        tick();
        tests_run++;
        if (busy !== 8'h10) begin tests_failed++; $display("FAIL rsv_r0_busy got %h exp 10", busy); end
        rsv_addr   = 3'd2;
        req0_valid = 1'b1;
        req0_addr  = 3'd4;
        req0_data  = 8'hC4;
        tick();
        rsv_valid  = 1'b0;
        req0_valid = 1'b0;
        tests_run++;
        if (busy !== 8'h04) begin tests_failed++; $display("FAIL rsv_set_and_clr got %h exp 04", busy); end
        rd_addr2 = 3'd2;
        #1;
        tests_run++;
        if (hazard !== 1'b1) begin tests_failed++; $display("FAIL hazard_rd2 got %b exp 1", hazard); end
        rd_addr2   = 3'd0;
        req1_valid = 1'b1;
        req1_addr  = 3'd2;
        req1_data  = 8'h02;
        tick();
        req1_valid = 1'b0;
        tests_run++;
        if (busy !== 8'h00) begin tests_failed++; $display("FAIL rsv_final_clr got %h exp 00", busy); end
        tick();
    endtask

    task automatic test_addr_zero();
        req1_valid = 1'b1;
        req1_addr  = 3'd0;
        req1_data  = 8'hFF;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL addr0_ready got %b exp 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        tests_run++;
        if (write !== 1'b0 || busy !== 8'h00) begin
            tests_failed++; $display("FAIL addr0_write got %b busy %h exp 0 00", write, busy);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        rsv_valid = 1'b1;
        rsv_addr  = 3'd6;
        tick();
        rsv_addr   = 3'd7;
        req0_valid = 1'b1;
        req0_addr  = 3'd6;
        req0_data  = 8'h66;
        tick();
        rsv_valid  = 1'b0;
        req0_valid = 1'b0;
        tests_run++;
        if (busy !== 8'h80 || write !== 1'b1 || wr_addr !== 3'd6) begin
            tests_failed++; $display("FAIL midrst_pre got busy %h wr %b/%0d exp 80 1/6", busy, write, wr_addr);
        end
        rst        = 1'b1;
        rsv_valid  = 1'b1;
        rsv_addr   = 3'd1;
        req0_valid = 1'b1;
        req0_addr  = 3'd1;
        req1_valid = 1'b1;
        req1_addr  = 3'd2;
        #1;
        tests_run++;
        if (rsv_ready !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_ready got %b%b%b exp 000", rsv_ready, req1_ready, req0_ready);
        end
        tick();
        idle_inputs();
        rst = 1'b0;
        tests_run++;
        if (busy !== 8'h00 || write !== 1'b0 || wr_data !== 8'h00) begin
            tests_failed++; $display("FAIL midrst_state got busy %h wr %b data %h exp 00 0 00", busy, write, wr_data);
        end
        tick();
        tests_run++;
        if (busy !== 8'h00 || write !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_after got busy %h wr %b exp 00 0", busy, write);
        end
        // Port 0 was granted last before reset; reset must restore port-0 priority.
        req0_valid = 1'b1; req0_addr = 3'd1;
        req1_valid = 1'b1; req1_addr = 3'd2;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL midrst_ptr got %b%b exp 01", req1_ready, req0_ready);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_writeback();
        test_hazard();
        test_round_robin();
        test_reservation_rules();
        test_addr_zero();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: write-back data width.
REQ-002 Parameter ADDR_W, default 3: register address width (2**ADDR_W registers).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rsv_valid  in  1  issue stage requests a destination reservation.
REQ-007 rsv_addr  in  ADDR_W  destination register to reserve.
REQ-008 rsv_ready  out  ADDR_W-independent 1  reservation accepted this cycle.
REQ-009 req0_valid / req0_addr / req0_data  in  1 / ADDR_W / DATA_W  write-back request, ALU port.
REQ-010 req0_ready  out  1  port 0 granted this cycle.
REQ-011 req1_valid / req1_addr / req1_data  in  1 / ADDR_W / DATA_W  write-back request, load port.
REQ-012 req1_ready  out  1  port 1 granted this cycle.
REQ-013 rd_addr1, rd_addr2  in  ADDR_W each  source registers of the instruction in decode.
REQ-014 hazard  out  1  decode must stall.
REQ-015 write / wr_addr / wr_data  out  1 / ADDR_W / DATA_W  registered register-file write port.
REQ-016 busy  out  2**ADDR_W  scoreboard bit per register.

Function
REQ-017 Scoreboard: busy[0] SHALL be constant 0; reservations and clears of r0 are ignored.
REQ-018 rsv_ready = !rst && (rsv_addr==0 || !busy[rsv_addr]); combinational.
REQ-019 rsv_valid && rsv_ready && rsv_addr!=0 SHALL set busy[rsv_addr] at the next edge.
REQ-020 Arbiter: at most one grant per cycle; a sole valid requester is granted; both valid -> grant the port not granted most recently.
REQ-021 Round-robin pointer SHALL update only on a grant; after reset port 0 has priority.
REQ-022 reqN_ready is combinational, asserted only for the granted port, never during rst.
REQ-023 Grant at edge T: write=1, wr_addr, wr_data SHALL hold the granted request during cycle T+1; write=0 in any cycle with no prior grant.
REQ-024 Grant with addr 0: handshake completes, write stays 0 (write discarded).
REQ-025 Grant SHALL clear busy[addr] at the same edge the write output is registered; no check that the bit was set.
REQ-026 Reservation and clear of the same register in one cycle cannot occur (rsv_ready low while busy); a reservation of register A with a clear of register B SHALL both take effect.
REQ-027 hazard = for rd_addr1 or rd_addr2 (each !=0): busy[rd] || (write && wr_addr==rd); combinational, covers the cycle between grant and register-file update.
REQ-028 Latency: request accepted at edge T, register file updated at edge T+2, hazard for that register deasserts in cycle T+2.

Reset
REQ-029 rst SHALL clear busy to 0, write to 0, wr_addr to 0, wr_data to 0, pointer to port-0 priority.
REQ-030 rst mid-operation SHALL drop all reservations and any in-flight write; requests/reservations presented during rst are not accepted.

Structure
REQ-031 DATA_W, ADDR_W defaults and NUM_REGS SHALL live in the shared package tiny_pkg.
REQ-032 Two-port round-robin arbitration SHALL be a sub-module rr_arbiter2 (req[1:0], grant[1:0], pointer state).

Verification
REQ-033 Reserve r3, then req0 addr3 data 0x5A -> busy[3]=1 then 0; write=1 wr_addr=3 wr_data=0x5A exactly one cycle after req0_ready.
REQ-034 req0 (r1,0x11) and req1 (r2,0x22) valid for 3 cycles -> grants port0, port1, port0; writes follow in same order.
REQ-035 busy[4]=1, rsv_valid rsv_addr=4 -> rsv_ready=0, busy unchanged; rsv_addr=0 -> rsv_ready=1, busy stays 0.
REQ-036 rd_addr1=5, r5 reserved, write-back granted at edge T -> hazard=1 through cycle T+1, 0 in T+2.
REQ-037 req1 addr 0 data 0xFF -> req1_ready=1, write stays 0.
REQ-038 Reserve r6, r7, assert rst one cycle -> busy=0x00, write=0, rsv_ready=0 during rst.
